// File: rtl/fpu_pkg.sv
// Shared encodings for the FPU issue controller: opcodes, rounding modes,
// exception-flag bit order and FSM state encoding.
package fpu_pkg;

  localparam logic [6:0] F7_FADD_S    = 7'b0000000;
  localparam logic [6:0] F7_FADD_D    = 7'b0000001;
  localparam logic [6:0] F7_FSUB_S    = 7'b0000100;
  localparam logic [6:0] F7_FSUB_D    = 7'b0000101;
  localparam logic [6:0] F7_FSGNJ_S   = 7'b0010000;
  localparam logic [6:0] F7_FSGNJ_D   = 7'b0010001;
  localparam logic [6:0] F7_FMINMAX_S = 7'b0010100;
  localparam logic [6:0] F7_FMINMAX_D = 7'b0010101;
  localparam logic [6:0] F7_FCMP_S    = 7'b1010000;
  localparam logic [6:0] F7_FCMP_D    = 7'b1010001;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic [2:0] rm_effective(input logic [2:0] req_rm,
                                              input logic [2:0] frm);
    return (req_rm == RM_DYN) ? frm : req_rm;
  endfunction

  // Only the five IEEE modes are executable; 101/110 are reserved and a
  // dynamic mode that resolves to 111 is meaningless.
  function automatic logic rm_illegal(input logic [2:0] rm);
    logic ill;
    case (rm)
      RM_RNE, RM_RTZ, RM_RDN, RM_RUP, RM_RMM: ill = 1'b0;
      default:                                ill = 1'b1;
    endcase
    return ill;
  endfunction

  function automatic logic is_compare(input logic [6:0] f7);
    return (f7 == F7_FCMP_S) || (f7 == F7_FCMP_D);
  endfunction

  function automatic logic is_supported(input logic [6:0] f7);
    logic sup;
    case (f7)
      F7_FADD_S, F7_FADD_D, F7_FSUB_S, F7_FSUB_D,
      F7_FSGNJ_S, F7_FSGNJ_D, F7_FMINMAX_S, F7_FMINMAX_D,
      F7_FCMP_S, F7_FCMP_D: sup = 1'b1;
      default:              sup = 1'b0;
    endcase
    return sup;
  endfunction

  function automatic logic [4:0] pack_flags(input logic nv, input logic dz,
                                            input logic of, input logic uf,
                                            input logic nx);
    logic [4:0] f;
    f          = '0;
    f[FLAG_NV] = nv;
    f[FLAG_DZ] = dz;
    f[FLAG_OF] = of;
    f[FLAG_UF] = uf;
    f[FLAG_NX] = nx;
    return f;
  endfunction

endpackage

// File: rtl/fpu_rsp_format.sv
// Shapes the raw FPU result into the architectural response value:
// compare bit, NaN-boxed single, or the raw 64-bit result.
module fpu_rsp_format
  import fpu_pkg::*;
(
  input  logic [6:0]  func7_i,
  input  logic [63:0] result_i,
  input  logic        cmp_i,
  output logic [63:0] result_o
);

  // Unrecognised opcodes pass the FPU's own (double-width) answer through.
  always_comb begin
    result_o = result_i;
    if (is_compare(func7_i)) begin
      result_o = {63'b0, cmp_i};
    end else if (is_supported(func7_i) && !func7_i[0]) begin
      result_o = {32'hFFFF_FFFF, result_i[31:0]};
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-outstanding issue controller: accepts one request, drives the FPU
// for LATENCY cycles, captures and formats the result, then hands it back.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_func7,
  input  logic [2:0]  req_func3,
  input  logic [2:0]  req_rm,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [3:0]  req_tag,
  input  logic [2:0]  csr_frm,
  input  logic        fflags_clr,
  output logic [6:0]  fpu_func7,
  output logic [2:0]  fpu_func3,
  output logic [2:0]  fpu_rm,
  output logic [63:0] fpu_a,
  output logic [63:0] fpu_b,
  input  logic [63:0] fpu_result,
  input  logic        fpu_nv,
  input  logic        fpu_dz,
  input  logic        fpu_of,
  input  logic        fpu_uf,
  input  logic        fpu_nx,
  input  logic        fpu_cmp,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_result,
  output logic [4:0]  rsp_flags,
  output logic [3:0]  rsp_tag,
  output logic        rsp_illegal,
  output logic [4:0]  fflags
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  tag_q, tag_d;
  logic [6:0]  fpu_func7_q, fpu_func7_d;
  logic [2:0]  fpu_func3_q, fpu_func3_d;
  logic [2:0]  fpu_rm_q, fpu_rm_d;
  logic [63:0] fpu_a_q, fpu_a_d;
  logic [63:0] fpu_b_q, fpu_b_d;
  logic [63:0] rsp_result_q, rsp_result_d;
  logic [4:0]  rsp_flags_q, rsp_flags_d;
  logic [3:0]  rsp_tag_q, rsp_tag_d;
  logic        rsp_illegal_q, rsp_illegal_d;
  logic [4:0]  fflags_q, fflags_d;

  logic [2:0]  eff_rm;
  logic [4:0]  ret_flags;
  logic [63:0] fmt_result;
  logic        capture;

  assign eff_rm    = rm_effective(req_rm, csr_frm);
  assign ret_flags = pack_flags(fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx);

  // The opcode driven to the FPU is the one whose result is being captured.
  fpu_rsp_format u_fmt (
    .func7_i  (fpu_func7_q),
    .result_i (fpu_result),
    .cmp_i    (fpu_cmp),
    .result_o (fmt_result)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tag_d         = tag_q;
    fpu_func7_d   = fpu_func7_q;
    fpu_func3_d   = fpu_func3_q;
    fpu_rm_d      = fpu_rm_q;
    fpu_a_d       = fpu_a_q;
    fpu_b_d       = fpu_b_q;
    rsp_result_d  = rsp_result_q;
    rsp_flags_d   = rsp_flags_q;
    rsp_tag_d     = rsp_tag_q;
    rsp_illegal_d = rsp_illegal_q;
    fflags_d      = fflags_q;
    capture       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          tag_d = req_tag;
          if (rm_illegal(eff_rm)) begin
            // Rejected without touching the FPU or the accrued flags.
            rsp_result_d  = '0;
            rsp_flags_d   = '0;
            rsp_tag_d     = req_tag;
            rsp_illegal_d = 1'b1;
            state_d       = ST_RESP;
          end else begin
            fpu_func7_d = req_func7;
            fpu_func3_d = req_func3;
            fpu_rm_d    = eff_rm;
            fpu_a_d     = req_a;
            fpu_b_d     = req_b;
            cnt_d       = CNT_INIT;
            state_d     = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          capture       = 1'b1;
          rsp_result_d  = fmt_result;
          rsp_flags_d   = ret_flags;
          rsp_tag_d     = tag_q;
          rsp_illegal_d = 1'b0;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A clear coinciding with a capture keeps only the new op's flags.
    if (capture) begin
      fflags_d = fflags_clr ? ret_flags : (fflags_q | ret_flags);
    end else if (fflags_clr) begin
      fflags_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      tag_q         <= '0;
      fpu_func7_q   <= '0;
      fpu_func3_q   <= '0;
      fpu_rm_q      <= '0;
      fpu_a_q       <= '0;
      fpu_b_q       <= '0;
      rsp_result_q  <= '0;
      rsp_flags_q   <= '0;
      rsp_tag_q     <= '0;
      rsp_illegal_q <= 1'b0;
      fflags_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tag_q         <= tag_d;
      fpu_func7_q   <= fpu_func7_d;
      fpu_func3_q   <= fpu_func3_d;
      fpu_rm_q      <= fpu_rm_d;
      fpu_a_q       <= fpu_a_d;
      fpu_b_q       <= fpu_b_d;
      rsp_result_q  <= rsp_result_d;
      rsp_flags_q   <= rsp_flags_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_illegal_q <= rsp_illegal_d;
      fflags_q      <= fflags_d;
    end
  end

  // req_ready is held low while reset is asserted.
  assign req_ready   = (state_q == ST_IDLE) && !rst;
  assign rsp_valid   = (state_q == ST_RESP);
  assign fpu_func7   = fpu_func7_q;
  assign fpu_func3   = fpu_func3_q;
  assign fpu_rm      = fpu_rm_q;
  assign fpu_a       = fpu_a_q;
  assign fpu_b       = fpu_b_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_flags   = rsp_flags_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_illegal = rsp_illegal_q;
  assign fflags      = fflags_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl; the bench plays the FPU, returning
// hand-computed answers only in the cycle the controller should sample them.
module tb_fpu_issue_ctrl;

  localparam int LAT = 3;
  localparam logic [63:0] GARB = 64'hBAD0_BAD0_BAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [6:0]  req_func7 = '0;
  logic [2:0]  req_func3 = '0;
  logic [2:0]  req_rm = '0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [3:0]  req_tag = '0;
  logic [2:0]  csr_frm = '0;
  logic        fflags_clr = 1'b0;
  logic [6:0]  fpu_func7;
  logic [2:0]  fpu_func3;
  logic [2:0]  fpu_rm;
  logic [63:0] fpu_a;
  logic [63:0] fpu_b;
  logic [63:0] fpu_result = GARB;
  logic        fpu_nv = 1'b1, fpu_dz = 1'b1, fpu_of = 1'b1, fpu_uf = 1'b1, fpu_nx = 1'b1;
  logic        fpu_cmp = 1'b1;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_result;
  logic [4:0]  rsp_flags;
  logic [3:0]  rsp_tag;
  logic        rsp_illegal;
  logic [4:0]  fflags;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_func7(req_func7), .req_func3(req_func3), .req_rm(req_rm),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .csr_frm(csr_frm), .fflags_clr(fflags_clr),
    .fpu_func7(fpu_func7), .fpu_func3(fpu_func3), .fpu_rm(fpu_rm),
    .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_result(fpu_result), .fpu_nv(fpu_nv), .fpu_dz(fpu_dz),
    .fpu_of(fpu_of), .fpu_uf(fpu_uf), .fpu_nx(fpu_nx), .fpu_cmp(fpu_cmp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
    .rsp_illegal(rsp_illegal), .fflags(fflags)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fpu_garbage();
    fpu_result = GARB;
    {fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx} = 5'b11111;
    fpu_cmp = 1'b1;
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, ":req_ready"},   req_ready,   0);
    check({nm, ":rsp_valid"},   rsp_valid,   0);
    check({nm, ":fpu_func7"},   fpu_func7,   0);
    check({nm, ":fpu_func3"},   fpu_func3,   0);
    check({nm, ":fpu_rm"},      fpu_rm,      0);
    check({nm, ":fpu_a"},       fpu_a,       0);
    check({nm, ":fpu_b"},       fpu_b,       0);
    check({nm, ":rsp_result"},  rsp_result,  0);
    check({nm, ":rsp_flags"},   rsp_flags,   0);
    check({nm, ":rsp_tag"},     rsp_tag,     0);
    check({nm, ":rsp_illegal"}, rsp_illegal, 0);
    check({nm, ":fflags"},      fflags,      0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where it is idle again.
  task automatic run_op(input string nm, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [2:0] rm, input logic [2:0] exp_rm,
                        input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag,
                        input logic [63:0] ret, input logic [4:0] rflags, input logic rcmp,
                        input logic exp_ill, input logic [63:0] exp_res,
                        input logic [4:0] exp_flags, input int hold, input logic clr_cap);
    check({nm, ":idle_req_ready"}, req_ready, 1);
    check({nm, ":idle_rsp_valid"}, rsp_valid, 0);
    req_valid = 1'b1; req_func7 = f7; req_func3 = f3; req_rm = rm;
    req_a = a; req_b = b; req_tag = tag;
    fpu_garbage();
    @(negedge clk);
    req_valid = 1'b0; req_func7 = ~f7; req_func3 = ~f3; req_a = ~a; req_b = ~b; req_tag = ~tag;
    if (!exp_ill) begin
      check({nm, ":fpu_func7"}, fpu_func7, f7);
      check({nm, ":fpu_func3"}, fpu_func3, f3);
      check({nm, ":fpu_rm"},    fpu_rm,    exp_rm);
      check({nm, ":fpu_a"},     fpu_a,     a);
      check({nm, ":fpu_b"},     fpu_b,     b);
      for (int k = 1; k <= LAT; k++) begin
        check({nm, ":exec_rsp_valid"}, rsp_valid, 0);
        check({nm, ":exec_req_ready"}, req_ready, 0);
        if (k == LAT) begin
          fpu_result = ret;
          {fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx} = rflags;
          fpu_cmp = rcmp;
          fflags_clr = clr_cap;
        end
        @(negedge clk);
        fflags_clr = 1'b0;
      end
      fpu_garbage();
    end
    for (int h = 0; h <= hold; h++) begin
      check({nm, ":rsp_valid"},   rsp_valid,   1);
      check({nm, ":req_ready"},   req_ready,   0);
      check({nm, ":rsp_result"},  rsp_result,  exp_res);
      check({nm, ":rsp_flags"},   rsp_flags,   exp_flags);
      check({nm, ":rsp_tag"},     rsp_tag,     tag);
      check({nm, ":rsp_illegal"}, rsp_illegal, exp_ill);
      if (h == hold) rsp_ready = 1'b1;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run_op("fadd_s", 7'b0000000, 3'b000, 3'b000, 3'b000, 64'h3F80_0000, 64'h4000_0000, 4'h1,
           64'h0000_0000_4040_0000, 5'b00000, 1'b0, 1'b0, 64'hFFFF_FFFF_4040_0000, 5'b00000, 0, 1'b0);
    check("fadd_s:fflags", fflags, 5'b00000);

    run_op("fcmp_d", 7'b1010001, 3'b010, 3'b000, 3'b000, 64'h3FF0_0000_0000_0000,
           64'h3FF0_0000_0000_0000, 4'h2, 64'h0, 5'b00000, 1'b1, 1'b0, 64'h1, 5'b00000, 0, 1'b0);

    run_op("unsup", 7'b0001000, 3'b000, 3'b000, 3'b000, 64'h7FF0_0000_0000_0000,
           64'hFFF0_0000_0000_0000, 4'h3, 64'h7FF8_0000_0000_0000, 5'b10000, 1'b0, 1'b0,
           64'h7FF8_0000_0000_0000, 5'b10000, 0, 1'b0);
    check("unsup:fflags", fflags, 5'b10000);

    run_op("fadd_d", 7'b0000001, 3'b000, 3'b000, 3'b000, 64'h3FF0_0000_0000_0000,
           64'h3FF0_0000_0000_0000, 4'h4, 64'h4000_0000_0000_0000, 5'b00000, 1'b0, 1'b0,
           64'h4000_0000_0000_0000, 5'b00000, 0, 1'b0);
    check("fadd_d:fflags_sticky", fflags, 5'b10000);

    csr_frm = 3'b101;
    run_op("illegal_rm", 7'b0000100, 3'b000, 3'b111, 3'b000, 64'h1234, 64'h5678, 4'h5,
           GARB, 5'b11111, 1'b1, 1'b1, 64'h0, 5'b00000, 0, 1'b0);
    check("illegal_rm:fpu_func7", fpu_func7, 7'b0000001);
    check("illegal_rm:fpu_a", fpu_a, 64'h3FF0_0000_0000_0000);
    check("illegal_rm:fflags", fflags, 5'b10000);

    csr_frm = 3'b010;
    run_op("dyn_rm", 7'b0000100, 3'b000, 3'b111, 3'b010, 64'h4040_0000, 64'h3F80_0000, 4'h6,
           64'h0000_0000_4000_0000, 5'b00000, 1'b0, 1'b0, 64'hFFFF_FFFF_4000_0000, 5'b00000, 0, 1'b0);

    csr_frm = 3'b000;
    run_op("hold_clr", 7'b0000000, 3'b000, 3'b000, 3'b000, 64'h3F80_0000, 64'h3380_0000, 4'h7,
           64'h0000_0000_3F80_0000, 5'b00001, 1'b0, 1'b0, 64'hFFFF_FFFF_3F80_0000, 5'b00001, 3, 1'b1);
    check("hold_clr:fflags_new_only", fflags, 5'b00001);

    fflags_clr = 1'b1;
    @(negedge clk);
    fflags_clr = 1'b0;
    check("idle_clr:fflags", fflags, 5'b00000);

    run_op("overflow", 7'b0000001, 3'b000, 3'b000, 3'b000, 64'h7FEF_FFFF_FFFF_FFFF,
           64'h7FEF_FFFF_FFFF_FFFF, 4'h8, 64'h7FF0_0000_0000_0000, 5'b00101, 1'b0, 1'b0,
           64'h7FF0_0000_0000_0000, 5'b00101, 0, 1'b0);
    check("overflow:fflags", fflags, 5'b00101);

    // Abort an operation mid-flight.
    req_valid = 1'b1; req_func7 = 7'b0000000; req_func3 = 3'b000; req_rm = 3'b000;
    req_a = 64'h3F80_0000; req_b = 64'h3F80_0000; req_tag = 4'h9;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort:in_exec", fpu_a, 64'h3F80_0000);
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort:req_ready_after", req_ready, 1);
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      check("abort:no_rsp", rsp_valid, 0);
    end

    run_op("post_abort", 7'b0000000, 3'b000, 3'b000, 3'b000, 64'h4000_0000, 64'h4000_0000, 4'hA,
           64'h0000_0000_4080_0000, 5'b00000, 1'b0, 1'b0, 64'hFFFF_FFFF_4080_0000, 5'b00000, 0, 1'b0);
    check("post_abort:fflags", fflags, 5'b00000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
